// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the dual-clock FIFO: pops DSIZE-bit entries and packs
// LANES of them into one wide word on a double-buffered valid/ready port.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int LANES = 4
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int CW = $clog2(LANES);

    logic [DSIZE-1:0]       acc [LANES];
    logic [CW-1:0]          cnt, cnt_n;
    logic                   fpend, fpend_n;
    logic [DSIZE*LANES-1:0] data_n;
    logic [LANES-1:0]       keep_n;
    logic                   valid_n;
    logic                   busy_n;
    logic                   ofree;
    logic                   last;

    assign ofree = !out_valid || out_ready;
    assign last  = (cnt == CW'(LANES - 1));

    // Gated by rrst so the FIFO never loses an entry while we are held in reset.
    assign rinc = !rrst && !rempty && !fpend && !(last && !ofree);

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path leaves it unassigned (no latches).
        cnt_n   = cnt;
        fpend_n = fpend;
        data_n  = out_data;
        keep_n  = out_keep;
        valid_n = out_valid;

        if (out_valid && out_ready)
            valid_n = 1'b0;

        if (rinc) begin
            cnt_n = last ? '0 : cnt + CW'(1);
            if (last) begin
                for (int i = 0; i < LANES; i++)
                    data_n[i*DSIZE +: DSIZE] = (i == LANES - 1) ? rdata : acc[i];
                keep_n  = '1;
                valid_n = 1'b1;
            end
        end

        // A flush only sets fpend; the partial word is emitted from the pending
        // state, which blocks pops, so it never collides with a full-word load.
        if (fpend) begin
            if (cnt == '0) begin
                fpend_n = 1'b0;
            end else if (ofree) begin
                for (int i = 0; i < LANES; i++) begin
                    keep_n[i]                = (CW'(i) < cnt);
                    data_n[i*DSIZE +: DSIZE] = (CW'(i) < cnt) ? acc[i] : '0;
                end
                valid_n = 1'b1;
                cnt_n   = '0;
                fpend_n = 1'b0;
            end
        end else if (flush) begin
            fpend_n = 1'b1;
        end

        busy_n = (cnt_n != '0) || valid_n || fpend_n;
    end

    always_ff @(posedge rclk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rrst) begin
            cnt       <= '0;
            fpend     <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            fpend     <= fpend_n;
            out_data  <= data_n;
            out_keep  <= keep_n;
            out_valid <= valid_n;
            busy      <= busy_n;
        end
    end

    // NOTE: the accumulator is small and is cleared on reset so a discarded partial word leaves no stale lanes behind.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < LANES; i++)
                acc[i] <= '0;
        end else if (rinc) begin
            acc[cnt] <= rdata;
        end
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the dual-clock FIFO, clocked in the read domain. It pops `DSIZE`-bit entries with the FIFO's `rinc`/`rempty` protocol and packs `LANES` consecutive entries into one wide word. The word is presented on a valid/ready output port. A flush request emits a partial word carrying a lane-keep mask. The output is double-buffered (accumulator plus output register), so the block sustains one pop per cycle while the downstream sink keeps up.

## Interface
- `DSIZE`, default 8: width of one FIFO entry.
- `LANES`, default 4: entries per output word; power of two, at least 2.

Ports (clock and reset first):
- `rclk`, in, 1: read-domain clock; all state changes on its rising edge.
- `rrst`, in, 1: reset; synchronous, active-high.
- `rdata`, in, `DSIZE`: FIFO head entry; valid whenever `rempty`=0.
- `rempty`, in, 1: FIFO empty flag.
- `rinc`, out, 1: pop strobe to the FIFO; combinational.
- `flush`, in, 1: single-cycle request to emit the partially filled word.
- `out_data`, out, `DSIZE*LANES`: packed word; lane 0 in bits [`DSIZE`-1:0]; the first popped entry goes to lane 0.
- `out_keep`, out, `LANES`: bit i set means lane i holds valid data.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: sink accepts the word.
- `busy`, out, 1: registered; 1 when `cnt`≠0, or `out_valid`=1, or `fpend`=1.

## Operation
Internal state:
- Accumulator `acc[LANES]`.
- Fill count `cnt`, 0..`LANES`-1, width log2(`LANES`).
- Flush-pending flag `fpend`.
- Output register holding `out_data`, `out_keep` and `out_valid`.

Definitions:
- `ofree` = !`out_valid` | `out_ready`: the output register can load this cycle.
- `last` = (`cnt` == `LANES`-1).

Pop and packing:
- `rinc` = !`rempty` & !`fpend` & !(`last` & !`ofree`).
- On a pop, `acc[cnt]` <= `rdata` and `cnt` <= `cnt`+1.
- If `last`, the completed word (the `acc` lanes plus `rdata` in the top lane) loads into the output register with `out_keep` = all ones, `out_valid` = 1, and `cnt` <= 0.

Output handshake:
- A transfer occurs when `out_valid` & `out_ready`.
- After a transfer, `out_valid` drops unless a new word loads in the same cycle.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_keep` hold stable.

Flush:
- `flush`=1 sets `fpend`.
- While `fpend`=1:
  - No pops occur.
  - If `cnt`=0, `fpend` clears on the next edge and no word is emitted.
  - If `cnt`>0 and `ofree`, the output loads the `cnt` filled lanes. Unfilled lanes are 0. `out_keep` = (1<<`cnt`)-1. `cnt` <= 0 and `fpend` <= 0.
  - If `cnt`>0 and `ofree`=0, the flush waits.
- Flush and pop in the same cycle: the pop completes first, then the flush applies to the updated `cnt`. If that pop completed a word, `cnt`=0 and the flush is a no-op.
- `flush` asserted while `fpend`=1 is absorbed; only one partial word is produced.

Reset:
- When `rrst`=1 on an edge: `cnt`=0, `acc`=0, `fpend`=0, `out_valid`=0, `out_data`=0, `out_keep`=0, `busy`=0.
- Reset overrides any pop or flush in the same cycle. `rinc` is forced to 0 while `rrst`=1, so no entry is lost.
- Reset mid-word discards the partial accumulator contents.

## Timing
- `rinc` is a same-cycle combinational function of `rempty`, `out_ready` and registered state. There is no combinational path from `rdata` or `flush` to `rinc`.
- Pop-to-output latency: the word whose last entry pops at edge N shows `out_valid`=1 after edge N.
- Throughput:
  - One entry per cycle.
  - One word every `LANES` cycles with `out_ready` held at 1.
  - No bubble when the output drains on the same edge that a word completes.
- Flush latency: `fpend` is set at edge N. The partial word appears after edge N+1 if the output register is free.
- `out_valid`, `out_data`, `out_keep` and `busy` are all registered.

## Test plan
1. Reset → all outputs 0, `rinc`=0 with `rrst`=1 even while `rempty`=0.
2. Streaming with `out_ready`=1: entries 0x11, 0x22, 0x33, 0x44, 0x55… popped on consecutive cycles → `out_data`=0x44332211, `out_keep`=4'b1111 one cycle after the 4th pop. Next word follows exactly 4 cycles later.
3. Backpressure: `out_ready`=0 with a word held and 3 more entries popped → `rinc`=0 at `cnt`=3. Raising `out_ready` → the 4th pop completes on the transfer edge with no data loss or duplication.
4. Flush after 0xAA, 0xBB → `out_data`=0x0000BBAA, `out_keep`=4'b0011. Flush with `cnt`=0 → no word, `fpend` clears after 1 cycle.
5. `flush` coincident with the 4th pop → one full word with keep 4'b1111, no empty partial word. `flush` repeated while pending → one partial word only.
6. `rrst` asserted with `cnt`=2 and `out_valid`=1 → all state cleared next cycle. The next 4 pops form a fresh word starting at lane 0.
